// File: rtl/fifo_hex_display_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_hex_display_if
// Brief    : Read-side handshake between the hex display reader and byte FIFO.
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_hex_display_if;
  logic       RDREQ;
  logic       EMPTY;
  logic [7:0] Q;

  // master = the reader that issues RDREQ; slave = the FIFO that answers it
  modport master (output RDREQ, input EMPTY, input Q);
  modport slave  (input RDREQ, output EMPTY, output Q);
endinterface
`default_nettype wire

// File: rtl/fifo_hex_display.sv
`default_nettype none
// ============================================================================
// Module   : fifo_hex_display
// Brief    : Pops FIFO bytes, holds each on HEX1:HEX0 with a running count on
//            HEX3:HEX2, and latches the recurrence period of the first byte.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_hex_display #(
  parameter logic [31:0] HOLD_CYC = 32'd50000000
) (
  input  wire                CLK,
  input  wire                RST,
  input  wire                EN,
  fifo_hex_display_if.master rd_if,
  output logic [6:0]         HEX0,
  output logic [6:0]         HEX1,
  output logic [6:0]         HEX2,
  output logic [6:0]         HEX3,
  output logic               BUSY,
  output logic               REPEAT,
  output logic [8:0]         PERIOD
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_CAP  = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam logic [31:0] c_hold_last = HOLD_CYC - 32'd1;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_rdreq;
  logic        r_busy;

  logic [7:0]  r_byte;
  logic [7:0]  r_count;
  logic [31:0] r_hold;

  logic [7:0]  r_first;
  logic        r_first_valid;
  logic [8:0]  r_period_cnt;
  logic        r_repeat;
  logic [8:0]  r_period;
  logic [8:0]  w_period_inc;

  // ------------------------------------------------------------------
  // Control FSM
  // ------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_rdreq <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      // outputs registered from the next state so they line up with r_state
      r_rdreq <= (w_state_next == S_RD);
      r_busy  <= (w_state_next != S_IDLE);
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (EN && !rd_if.EMPTY) begin
          w_state_next = S_RD;
        end
      end
      S_RD: begin
        w_state_next = S_CAP;
      end
      S_CAP: begin
        w_state_next = S_HOLD;
      end
      S_HOLD: begin
        if (r_hold == c_hold_last) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign rd_if.RDREQ = r_rdreq;
  assign BUSY        = r_busy;

  // ------------------------------------------------------------------
  // Display datapath and hold timer
  // ------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_byte  <= 8'h00;
      r_count <= 8'h00;
      r_hold  <= 32'd0;
    end else begin
      if (r_state == S_CAP) begin
        r_byte  <= rd_if.Q;
        r_count <= r_count + 8'd1;
        r_hold  <= 32'd0;
      end else if (r_state == S_HOLD) begin
        r_hold  <= r_hold + 32'd1;
      end
    end
  end

  // ------------------------------------------------------------------
  // Period detection, frozen once the first byte has come round again
  // ------------------------------------------------------------------
  assign w_period_inc = (r_period_cnt == 9'h1FF) ? 9'h1FF : (r_period_cnt + 9'd1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_first       <= 8'h00;
      r_first_valid <= 1'b0;
      r_period_cnt  <= 9'd0;
      r_repeat      <= 1'b0;
      r_period      <= 9'd0;
    end else if (r_state == S_CAP) begin
      if (!r_first_valid) begin
        r_first       <= rd_if.Q;
        r_first_valid <= 1'b1;
        r_period_cnt  <= 9'd0;
      end else if (!r_repeat) begin
        r_period_cnt <= w_period_inc;
        if (rd_if.Q == r_first) begin
          r_repeat <= 1'b1;
          r_period <= w_period_inc;
        end
      end
    end
  end

  assign REPEAT = r_repeat;
  assign PERIOD = r_period;

  // ------------------------------------------------------------------
  // Active-low 7-segment decode, bit order g..a
  // ------------------------------------------------------------------
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] seg;
    unique case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  assign HEX0 = seg7(r_byte[3:0]);
  assign HEX1 = seg7(r_byte[7:4]);
  assign HEX2 = seg7(r_count[3:0]);
  assign HEX3 = seg7(r_count[7:4]);

endmodule
`default_nettype wire

// File: tb/tb_fifo_hex_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_hex_display
// Brief    : Self-checking bench for fifo_hex_display against a byte-history model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_hex_display;

  localparam int HOLD = 4;
  localparam logic [6:0] SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  localparam logic [6:0] D0 = 7'b1000000;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       EN  = 1'b0;
  logic [6:0] HEX0, HEX1, HEX2, HEX3;
  logic       BUSY, REPEAT;
  logic [8:0] PERIOD;

  fifo_hex_display_if bus ();

  fifo_hex_display #(.HOLD_CYC(32'(HOLD))) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .rd_if(bus),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
    .BUSY(BUSY), .REPEAT(REPEAT), .PERIOD(PERIOD)
  );

  always #5 CLK = ~CLK;

  // FIFO model in normal mode: data appears the cycle after RDREQ
  logic [7:0] mem [0:2047];
  int   wr_ptr = 0;
  int   rd_ptr = 0;
  logic underflow = 1'b0;

  assign bus.EMPTY = (wr_ptr == rd_ptr);

  always @(posedge CLK) begin
    if (bus.RDREQ) begin
      if (rd_ptr != wr_ptr) begin
        bus.Q  <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1;
      end else begin
        underflow <= 1'b1;
      end
    end
  end

  int total = 0;
  int bad   = 0;
  logic [7:0] pending [$];
  logic [7:0] hist [$];

  // Expected display: last byte shown and number of bytes since reset mod 256
  function automatic logic [27:0] exp_hex();
    logic [7:0] c;
    logic [7:0] b;
    c = 8'(hist.size());
    b = (hist.size() > 0) ? hist[hist.size() - 1] : 8'h00;
    return {SEG[c[7:4]], SEG[c[3:0]], SEG[b[7:4]], SEG[b[3:0]]};
  endfunction

  // Expected {REPEAT, PERIOD}: distance to first recurrence of the first byte
  function automatic logic [9:0] exp_rp();
    for (int i = 1; i < hist.size(); i++) begin
      if (hist[i] == hist[0]) return {1'b1, (i > 511) ? 9'd511 : 9'(i)};
    end
    return 10'd0;
  endfunction

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr      = wr_ptr + 1;
    pending.push_back(b);
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RST = 1'b1;
    EN  = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    hist.delete();
  endtask

  task automatic drain(output bit ok);
    int lim;
    lim = pending.size() * (HOLD + 3) + 20;
    ok  = 1'b0;
    EN  = 1'b1;
    for (int i = 0; i < lim; i++) begin
      @(negedge CLK);
      if (bus.EMPTY && !BUSY) begin
        ok = 1'b1;
        break;
      end
    end
    EN = 1'b0;
    while (pending.size() > 0) hist.push_back(pending.pop_front());
  endtask

  task automatic test_reset();
    bit found;
    RST = 1'b1;
    EN  = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    total++;
    if ({bus.RDREQ, BUSY, REPEAT, PERIOD} !== 12'd0) begin
      bad++; $display("FAIL reset_flags: got %b want 0", {bus.RDREQ, BUSY, REPEAT, PERIOD});
    end
    total++;
    if ({HEX3, HEX2, HEX1, HEX0} !== {4{D0}}) begin
      bad++; $display("FAIL reset_hex: got %h want %h", {HEX3, HEX2, HEX1, HEX0}, {4{D0}});
    end

    push(8'h3C);
    EN    = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge CLK);
      found = bus.RDREQ;
    end
    total++;
    if (!found) begin bad++; $display("FAIL reset_read_start: got no RDREQ want RDREQ"); end
    repeat (3) @(negedge CLK);
    total++;
    if (BUSY !== 1'b1) begin bad++; $display("FAIL reset_in_hold: got BUSY=%b want 1", BUSY); end
    RST = 1'b1;
    EN  = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    pending.delete();
    hist.delete();
    total++;
    if ({bus.RDREQ, BUSY, REPEAT, PERIOD} !== 12'd0 || {HEX3, HEX2, HEX1, HEX0} !== {4{D0}}) begin
      bad++; $display("FAIL reset_mid_hold: got flags=%b hex=%h want 0 and %h",
                      {bus.RDREQ, BUSY, REPEAT, PERIOD}, {HEX3, HEX2, HEX1, HEX0}, {4{D0}});
    end
    repeat (5) @(negedge CLK);
    total++;
    if (BUSY !== 1'b0) begin bad++; $display("FAIL reset_stays_idle: got BUSY=%b want 0", BUSY); end
  endtask

  task automatic test_single();
    int first;
    int nrd;
    int nbusy;
    first = -1;
    nrd   = 0;
    nbusy = 0;
    push(8'hA5);
    EN = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (bus.RDREQ) begin
        nrd++;
        if (first < 0) first = i;
      end
      if (BUSY) nbusy++;
      if (first >= 0 && i == first + 1) begin
        total++;
        if ({HEX3, HEX2, HEX1, HEX0} !== {4{D0}}) begin
          bad++; $display("FAIL single_early: got %h want %h", {HEX3, HEX2, HEX1, HEX0}, {4{D0}});
        end
      end
      if (first >= 0 && i == first + 2) begin
        total++;
        if ({HEX3, HEX2, HEX1, HEX0} !== {D0, 7'b1111001, 7'b0001000, 7'b0010010}) begin
          bad++; $display("FAIL single_hex: got %h want %h", {HEX3, HEX2, HEX1, HEX0},
                          {D0, 7'b1111001, 7'b0001000, 7'b0010010});
        end
      end
    end
    EN = 1'b0;
    total++;
    if (nrd != 1) begin bad++; $display("FAIL single_rdreq_cycles: got %0d want 1", nrd); end
    total++;
    if (nbusy != HOLD + 2) begin bad++; $display("FAIL single_busy_cycles: got %0d want %0d", nbusy, HOLD + 2); end
    while (pending.size() > 0) hist.push_back(pending.pop_front());
  endtask

  task automatic test_gating();
    int nrd;
    int nbusy;
    bit found;
    bit ok;
    nrd = 0;
    EN  = 1'b1;
    repeat (20) begin
      @(negedge CLK);
      if (bus.RDREQ) nrd++;
    end
    total++;
    if (nrd != 0) begin bad++; $display("FAIL gate_empty: got %0d reads want 0", nrd); end

    EN = 1'b0;
    push(8'($urandom));
    push(8'($urandom));
    nrd   = 0;
    nbusy = 0;
    repeat (20) begin
      @(negedge CLK);
      if (bus.RDREQ) nrd++;
      if (BUSY) nbusy++;
    end
    total++;
    if (nrd != 0 || nbusy != 0) begin
      bad++; $display("FAIL gate_en_low: got reads=%0d busy=%0d want 0 0", nrd, nbusy);
    end

    EN    = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge CLK);
      found = bus.RDREQ;
    end
    total++;
    if (!found) begin bad++; $display("FAIL gate_read_start: got no RDREQ want RDREQ"); end
    repeat (2) @(negedge CLK);
    EN  = 1'b0;
    nrd = 0;
    repeat (20) begin
      @(negedge CLK);
      if (bus.RDREQ) nrd++;
    end
    total++;
    if (nrd != 0 || BUSY !== 1'b0) begin
      bad++; $display("FAIL gate_drop_en: got reads=%0d busy=%b want 0 0", nrd, BUSY);
    end
    hist.push_back(pending.pop_front());
    total++;
    if ({HEX3, HEX2, HEX1, HEX0} !== exp_hex()) begin
      bad++; $display("FAIL gate_hex: got %h want %h", {HEX3, HEX2, HEX1, HEX0}, exp_hex());
    end
    drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL gate_drain_timeout: got busy want idle"); end
    total++;
    if ({HEX3, HEX2, HEX1, HEX0} !== exp_hex()) begin
      bad++; $display("FAIL gate_drain_hex: got %h want %h", {HEX3, HEX2, HEX1, HEX0}, exp_hex());
    end
  endtask

  task automatic test_back_to_back();
    int idx [$];
    for (int k = 0; k < 3; k++) push(8'($urandom));
    EN = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (bus.RDREQ) idx.push_back(i);
    end
    EN = 1'b0;
    total++;
    if (idx.size() != 3) begin
      bad++; $display("FAIL b2b_reads: got %0d want 3", idx.size());
    end else begin
      for (int k = 1; k < 3; k++) begin
        total++;
        if (idx[k] - idx[k-1] != HOLD + 3) begin
          bad++; $display("FAIL b2b_spacing: got %0d want %0d", idx[k] - idx[k-1], HOLD + 3);
        end
      end
    end
    while (pending.size() > 0) hist.push_back(pending.pop_front());
    total++;
    if ({HEX3, HEX2, HEX1, HEX0} !== exp_hex() || BUSY !== 1'b0) begin
      bad++; $display("FAIL b2b_final: got hex=%h busy=%b want %h 0", {HEX3, HEX2, HEX1, HEX0}, BUSY, exp_hex());
    end
  endtask

  task automatic test_repeat();
    logic [7:0] seq [5];
    int idx [$];
    int rise;
    seq  = '{8'h10, 8'h20, 8'h30, 8'h10, 8'h40};
    rise = -1;
    apply_reset();
    for (int k = 0; k < 5; k++) push(seq[k]);
    EN = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (bus.RDREQ) idx.push_back(i);
      if (REPEAT === 1'b1 && rise < 0) rise = i;
    end
    EN = 1'b0;
    total++;
    if (idx.size() != 5 || rise != idx[3] + 2) begin
      bad++; $display("FAIL repeat_rise: got reads=%0d rise=%0d want 5 and 4th read+2", idx.size(), rise);
    end
    while (pending.size() > 0) hist.push_back(pending.pop_front());
    total++;
    if ({REPEAT, PERIOD} !== exp_rp()) begin
      bad++; $display("FAIL repeat_period: got %b/%0d want %b/%0d", REPEAT, PERIOD, exp_rp() >> 9, exp_rp() & 10'h1FF);
    end
    total++;
    if (PERIOD !== 9'd3) begin bad++; $display("FAIL repeat_period_abs: got %0d want 3", PERIOD); end
    total++;
    if ({HEX3, HEX2, HEX1, HEX0} !== exp_hex()) begin
      bad++; $display("FAIL repeat_hex: got %h want %h", {HEX3, HEX2, HEX1, HEX0}, exp_hex());
    end
  endtask

  task automatic test_random();
    bit ok;
    int n;
    apply_reset();
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(2, 7);
      for (int k = 0; k < n; k++) push(8'($urandom_range(0, 3)) * 8'h47);
      drain(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL rand_timeout: got busy want idle"); end
      total++;
      if ({HEX3, HEX2, HEX1, HEX0} !== exp_hex()) begin
        bad++; $display("FAIL rand_hex: got %h want %h", {HEX3, HEX2, HEX1, HEX0}, exp_hex());
      end
      total++;
      if ({REPEAT, PERIOD} !== exp_rp()) begin
        bad++; $display("FAIL rand_period: got %h want %h", {REPEAT, PERIOD}, exp_rp());
      end
    end
  endtask

  task automatic test_lfsr();
    logic [7:0] s;
    bit ok;
    apply_reset();
    s = 8'h01;
    for (int i = 0; i < 300; i++) begin
      push(s);
      s = s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
    end
    drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL lfsr_timeout: got busy want idle"); end
    total++;
    if (REPEAT !== 1'b1 || PERIOD !== 9'd255) begin
      bad++; $display("FAIL lfsr_period: got %b/%0d want 1/255", REPEAT, PERIOD);
    end
    total++;
    if ({HEX3, HEX2, HEX1, HEX0} !== exp_hex()) begin
      bad++; $display("FAIL lfsr_hex: got %h want %h", {HEX3, HEX2, HEX1, HEX0}, exp_hex());
    end
    for (int i = 0; i < 10; i++) push(8'($urandom));
    drain(ok);
    total++;
    if (!ok || {REPEAT, PERIOD} !== exp_rp()) begin
      bad++; $display("FAIL lfsr_frozen: got %b/%0d want %h", REPEAT, PERIOD, exp_rp());
    end
    total++;
    if ({HEX3, HEX2, HEX1, HEX0} !== exp_hex()) begin
      bad++; $display("FAIL lfsr_wrap_hex: got %h want %h", {HEX3, HEX2, HEX1, HEX0}, exp_hex());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_gating();
    test_back_to_back();
    test_repeat();
    test_random();
    test_lfsr();
    total++;
    if (underflow !== 1'b0) begin bad++; $display("FAIL fifo_underflow: got 1 want 0"); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
